execute_md_stage: RTL

//  Registered execute stage: ALU + branch-target adder, EX/MEM output register,

---
 rtl/execute_md_stage_if.sv | 38 +++
 rtl/execute_md_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_md_stage_if.sv
// rtl/execute_md_stage_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface execute_md_stage_if #(
    parameter int NB        = 32,
    parameter int NB_FCODE  = 6,
    parameter int NB_OPCODE = 6,
    parameter int NB_REG    = 5
);
    logic                 i_valid;
    logic                 i_flush;
    logic [NB_FCODE-1:0]  i_funct_code;
    logic [NB_OPCODE-1:0] i_op_code;
    logic                 i_alu_src;
    logic [NB-1:0]        i_data_a;
    logic [NB-1:0]        i_data_b;
    logic [NB-1:0]        i_extension_result;
    logic [NB-1:0]        i_pc4;
    logic [NB_REG-1:0]    i_rd_addr;
    logic                 i_reg_write;
    logic                 o_stall;
    logic                 o_valid;
    logic                 o_reg_write;
    logic [NB_REG-1:0]    o_rd_addr;
    logic [NB-1:0]        o_alu_result;
    logic                 o_cero;
    logic [NB-1:0]        o_branch_addr;

    modport master (
        output i_valid, i_flush, i_funct_code, i_op_code, i_alu_src, i_data_a, i_data_b,
               i_extension_result, i_pc4, i_rd_addr, i_reg_write,
        input  o_stall, o_valid, o_reg_write, o_rd_addr, o_alu_result, o_cero, o_branch_addr
    );

    modport slave (
        input  i_valid, i_flush, i_funct_code, i_op_code, i_alu_src, i_data_a, i_data_b,
               i_extension_result, i_pc4, i_rd_addr, i_reg_write,
        output o_stall, o_valid, o_reg_write, o_rd_addr, o_alu_result, o_cero, o_branch_addr
    );
endinterface

// File: rtl/execute_md_stage.sv
// rtl/execute_md_stage.sv - execute stage: ALU, branch adder, EX/MEM register, iterative mul/div with HI/LO (EXECUTE_MULDIV_EN)
module execute_md_stage #(
    parameter int NB        = 32,
    parameter int NB_FCODE  = 6,
    parameter int NB_OPCODE = 6,
    parameter int NB_REG    = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    execute_md_stage_if.slave bus
);
    localparam int SHW = $clog2(NB);
    localparam int CW  = $clog2(NB);

    localparam logic [NB_OPCODE-1:0] OP_RTYPE = 'h00, OP_BEQ = 'h04, OP_BNE = 'h05,
                                     OP_SLTI = 'h0A, OP_SLTIU = 'h0B, OP_ANDI = 'h0C,
                                     OP_ORI = 'h0D, OP_XORI = 'h0E, OP_LUI = 'h0F;
    localparam logic [NB_FCODE-1:0]  F_SUB = 'h22, F_SUBU = 'h23, F_AND = 'h24, F_OR = 'h25,
                                     F_XOR = 'h26, F_NOR = 'h27, F_SLT = 'h2A, F_SLTU = 'h2B,
                                     F_SLLV = 'h04, F_SRLV = 'h06, F_SRAV = 'h07,
                                     F_MFHI = 'h10, F_MTHI = 'h11, F_MFLO = 'h12, F_MTLO = 'h13;

    logic [NB-1:0] op_a, op_b, alu_result, hi_q, lo_q;
    logic          is_md, is_mt, writes_rf, stall;

    assign op_a      = bus.i_data_a;
    assign op_b      = bus.i_alu_src ? bus.i_extension_result : bus.i_data_b;
    assign is_md     = (bus.i_op_code == OP_RTYPE) && (bus.i_funct_code[NB_FCODE-1:2] == 4'b0110);
    assign is_mt     = (bus.i_op_code == OP_RTYPE) &&
                       ((bus.i_funct_code == F_MTHI) || (bus.i_funct_code == F_MTLO));
    assign writes_rf = bus.i_reg_write && !is_md && !is_mt;

    // Unlisted R-type functs and loads/stores fall through to an add
    always_comb begin
        alu_result = op_a + op_b;
        if (bus.i_op_code == OP_RTYPE) begin
            case (bus.i_funct_code)
                F_SUB, F_SUBU: alu_result = op_a - op_b;
                F_AND:         alu_result = op_a & op_b;
                F_OR:          alu_result = op_a | op_b;
                F_XOR:         alu_result = op_a ^ op_b;
                F_NOR:         alu_result = ~(op_a | op_b);
                F_SLT:         alu_result = {{(NB-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                F_SLTU:        alu_result = {{(NB-1){1'b0}}, (op_a < op_b)};
                F_SLLV:        alu_result = op_b << op_a[SHW-1:0];
                F_SRLV:        alu_result = op_b >> op_a[SHW-1:0];
                F_SRAV:        alu_result = $unsigned($signed(op_b) >>> op_a[SHW-1:0]);
                F_MFHI:        alu_result = hi_q;
                F_MFLO:        alu_result = lo_q;
                default:       alu_result = op_a + op_b;
            endcase
        end else begin
            case (bus.i_op_code)
                OP_BEQ, OP_BNE: alu_result = op_a - op_b;
                OP_SLTI:        alu_result = {{(NB-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                OP_SLTIU:       alu_result = {{(NB-1){1'b0}}, (op_a < op_b)};
                OP_ANDI:        alu_result = op_a & op_b;
                OP_ORI:         alu_result = op_a | op_b;
                OP_XORI:        alu_result = op_a ^ op_b;
                OP_LUI:         alu_result = {op_b[NB/2-1:0], {(NB/2){1'b0}}};
                default:        alu_result = op_a + op_b;
            endcase
        end
    end

`ifdef EXECUTE_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [NB-1:0]   md_hi, md_lo, md_b, md_a, a_mag, b_mag, quo, rem, hi_d, lo_d;
    logic [2*NB-1:0] prod;
    logic [NB:0]     mul_sum, div_shift, div_diff;
    logic            md_div, md_neg_q, md_neg_r, md_dz, md_signed, a_neg, b_neg, start;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        case (state)
            S_IDLE: if (bus.i_valid && is_md) begin
                start     = 1'b1;
                stall     = 1'b1;
                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                if (cnt == CW'(NB-1)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.i_flush) begin
            state_nxt = S_IDLE;
            stall     = 1'b0;
            start     = 1'b0;
        end
    end

    // Both units iterate on magnitudes; signs are reapplied when HI/LO are written
    assign md_signed = ~bus.i_funct_code[0];
    assign a_neg     = md_signed && op_a[NB-1];
    assign b_neg     = md_signed && bus.i_data_b[NB-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -bus.i_data_b : bus.i_data_b;
    assign mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
    assign div_shift = {md_hi, md_lo[NB-1]};
    assign div_diff  = div_shift - {1'b0, md_b};
    assign quo       = md_neg_q ? -md_lo : md_lo;
    assign rem       = md_neg_r ? -md_hi : md_hi;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        prod = {md_hi, md_lo};
        if (md_neg_q) prod = -prod;
        if (!bus.i_flush) begin
            if (state == S_DONE) begin
                if (!md_div) begin
                    hi_d = prod[2*NB-1:NB];
                    lo_d = prod[NB-1:0];
                end else if (md_dz) begin
                    hi_d = md_a;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end else if (state == S_IDLE && bus.i_valid && is_mt) begin
                if (bus.i_funct_code == F_MTHI) hi_d = op_a;
                else                            lo_d = op_a;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            md_hi    <= '0;
            md_lo    <= '0;
            md_b     <= '0;
            md_a     <= '0;
            md_div   <= 1'b0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_dz    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state <= state_nxt;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (start) begin
                cnt      <= '0;
                md_hi    <= '0;
                md_lo    <= a_mag;
                md_b     <= b_mag;
                md_a     <= op_a;
                md_div   <= bus.i_funct_code[1];
                md_neg_q <= a_neg ^ b_neg;
                md_neg_r <= a_neg;
                md_dz    <= (bus.i_data_b == '0);
            end else if (state == S_BUSY) begin
                cnt <= cnt + 1'b1;
                if (md_div) begin
                    md_hi <= div_diff[NB] ? div_shift[NB-1:0] : div_diff[NB-1:0];
                    md_lo <= {md_lo[NB-2:0], ~div_diff[NB]};
                end else begin
                    md_hi <= mul_sum[NB:1];
                    md_lo <= {mul_sum[0], md_lo[NB-1:1]};
                end
            end
        end
    end
`else
    assign stall = 1'b0;
    assign hi_q  = '0;
    assign lo_q  = '0;
`endif

    assign bus.o_stall = stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_valid       <= 1'b0;
            bus.o_reg_write   <= 1'b0;
            bus.o_rd_addr     <= '0;
            bus.o_alu_result  <= '0;
            bus.o_cero        <= 1'b0;
            bus.o_branch_addr <= '0;
        end else begin
            bus.o_rd_addr     <= bus.i_rd_addr;
            bus.o_alu_result  <= alu_result;
            bus.o_cero        <= (alu_result == '0);
            bus.o_branch_addr <= bus.i_pc4 + (bus.i_extension_result << 2);
            if (bus.i_flush || stall || !bus.i_valid) begin
                bus.o_valid     <= 1'b0;
                bus.o_reg_write <= 1'b0;
            end else begin
                bus.o_valid     <= 1'b1;
                bus.o_reg_write <= writes_rf;
            end
        end
    end
endmodule
